// File: rtl/restoring_divider.sv
// restoring_divider
//   Sequential unsigned restoring divider. One trial subtraction per clock
//   (shifted partial remainder minus divisor, borrow-in 0). The borrow-out
//   of that subtraction selects the quotient bit and whether the partial
//   remainder is restored. A WIDTH-bit quotient/remainder pair is produced
//   WIDTH+1 edges after an accepted start. Division by zero is resolved in
//   a single edge (quotient all ones, remainder = dividend).
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, priority over start
//   start        division request, sampled only while idle
//   dividend     unsigned dividend, captured on accepted start
//   divisor      unsigned divisor, captured on accepted start
//   busy         high while calculating or presenting a result
//   done         one-cycle pulse: quotient/remainder/div_by_zero valid
//   quotient     result quotient, held until overwritten by the next result
//   remainder    result remainder, held until overwritten by the next result
//   div_by_zero  set together with done when the captured divisor was zero

module restoring_divider #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] dvsr;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_res;     // {borrow_out, low WIDTH difference bits}
    logic             borrow;
    logic [WIDTH-1:0] r_new;
    logic [WIDTH-1:0] q_new;
    logic             last_iter;

    // Ripple full-subtractor chain, borrow-in 0, borrow travelling LSB to
    // MSB. Only the low WIDTH difference bits are returned: when there is no
    // borrow the difference is below the divisor, so its top bit is always 0.
    // The top stage contributes only its borrow-out.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] a,
                                                 input logic [WIDTH:0] b);
        logic [WIDTH:0] res;
        logic           bw;
        res = '0;
        bw  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            res[i] = a[i] ^ b[i] ^ bw;
            bw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        res[WIDTH] = (~a[WIDTH] & b[WIDTH]) | (~(a[WIDTH] ^ b[WIDTH]) & bw);
        return res;
    endfunction

    // Partial remainder is held in WIDTH bits: it is always below the
    // divisor, so the extra (WIDTH+1)-th bit only exists in 'shifted'.
    always_comb begin
        shifted   = {r_reg, q_reg[WIDTH-1]};
        sub_res   = trial_sub(shifted, {1'b0, dvsr});
        borrow    = sub_res[WIDTH];
        r_new     = borrow ? shifted[WIDTH-1:0] : sub_res[WIDTH-1:0];
        q_new     = {q_reg[WIDTH-2:0], ~borrow};
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor != '0) ? CALC : DONE;
            CALC: if (last_iter) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dvsr        <= divisor;
                            q_reg       <= dividend;
                            r_reg       <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_new;
                    r_reg <= r_new;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        quotient  <= q_new;
                        remainder <= r_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    restoring_divider #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, with the divide-by-zero convention.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic ez, output int elat);
        if (b == 0) begin
            eq = '1; er = a; ez = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; elat = W + 1;
        end
    endtask

    // Wait (bounded) for done after a start edge; returns edge count and
    // number of post-edge samples with busy high. Called right after the
    // start edge sample.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (busy) bcnt++;
    endtask

    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        logic ez;
        int elat, lat, bcnt;
        model(a, b, eq, er, ez, elat);
        dividend = a; divisor = b; start = 1'b1;
        tick();
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;   // must not affect result
        wait_done(lat, bcnt);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".busy_cycles"}, bcnt, elat);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dbz"}, div_by_zero, ez);
        tick();
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int lat, bcnt;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        do_div("basic", 20'd11, 20'd6);
        do_div("large", 20'd1000000, 20'd7);
        do_div("max_by_1", 20'hFFFFF, 20'd1);
        do_div("small", 20'd5, 20'd9);
        do_div("max_by_max", 20'hFFFFF, 20'hFFFFF);
        do_div("dbz", 20'd1234, 20'd0);
        do_div("dbz_clear", 20'd77, 20'd8);

        // Start while busy is ignored
        dividend = 20'd100; divisor = 20'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        dividend = 20'd50; divisor = 20'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, bcnt);
        chk("ign.done_seen", done, 1);
        chk("ign.q", quotient, 33);
        chk("ign.r", remainder, 1);
        tick();
        chk("ign.idle", busy, 0);

        // Start held high: back-to-back with one idle cycle between
        dividend = 20'd100; divisor = 20'd3; start = 1'b1;
        tick();
        wait_done(lat, bcnt);
        chk("b2b.first_lat", lat, W + 1);
        tick();
        chk("b2b.gap_idle", busy, 0);
        tick();
        chk("b2b.restart", busy, 1);
        wait_done(lat, bcnt);
        chk("b2b.second_lat", lat, W + 1);
        chk("b2b.q", quotient, 33);
        chk("b2b.r", remainder, 1);
        start = 1'b0;
        tick();

        // Reset in the middle of a division
        dividend = 20'd1000; divisor = 20'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("mid.busy_before", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid.busy", busy, 0);
        chk("mid.done", done, 0);
        chk("mid.q", quotient, 0);
        chk("mid.r", remainder, 0);
        rst = 1'b0;
        tick();
        do_div("after_rst", 20'd1000, 20'd10);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(0, 15));
                1:       b = W'($urandom) >> $urandom_range(1, 19);
                default: b = W'($urandom);
            endcase
            do_div("rand", a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Sequential unsigned integer divider for the ALU arithmetic group. It is the consumer of the 20-bit full subtractor stage. Each iteration issues one trial subtraction (A = shifted partial remainder, B = divisor, Bin = 0) and uses the borrow-out to decide the quotient bit. It produces one WIDTH-bit quotient and one WIDTH-bit remainder in WIDTH+1 cycles.

Parameters:
WIDTH, 20, operand/quotient/remainder width in bits (matches subtractor datapath)
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on accepted start
divisor  input  WIDTH  unsigned divisor; captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  WIDTH  result quotient; held until next accepted start
remainder  output  WIDTH  result remainder; held until next accepted start
div_by_zero  output  1  set with done when captured divisor == 0; held with results

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: on any edge with rst=1, the block enters IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. This holds mid-operation; no partial result survives. rst has priority over start.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and divisor!=0 at edge k: latch the divisor. Q_reg=dividend, R_reg=0 (WIDTH+1 bits), counter=0, div_by_zero cleared. Next state CALC.
  - start=1 and divisor==0 at edge k: quotient=all ones, remainder=dividend, div_by_zero=1. Next state DONE, so done is high in the cycle after edge k.
  - start=0: stay in IDLE; outputs hold.
- CALC: one iteration per edge.
  - shifted = {R_reg[WIDTH-1:0], Q_reg[WIDTH-1]} (WIDTH+1 bits).
  - trial = shifted - {1'b0, divisor}, computed with the full-subtractor equations (Bin=0, borrow chained LSB to MSB).
  - Borrow-out=0: R_reg=trial, new Q LSB=1.
  - Borrow-out=1: R_reg=shifted, new Q LSB=0.
  - Q_reg = {Q_reg[WIDTH-2:0], new LSB}. counter increments.
  - On the edge where counter==WIDTH-1 (the WIDTH-th iteration): write the final values to quotient and remainder (R_reg[WIDTH-1:0]). Next state DONE.
  - Latency: start accepted at edge k → iterations at edges k+1..k+WIDTH → done high during the cycle after edge k+WIDTH. That is WIDTH+1 edges; 21 for WIDTH=20.
- DONE: done=1 for exactly this one cycle. Next state IDLE unconditionally.
- busy: high in CALC and DONE.
- start while busy (CALC or DONE) is ignored and not queued. A new start can be accepted in the first IDLE cycle after DONE.
- Operands are captured at start; input changes during CALC have no effect.
- Arithmetic: unsigned only. The partial remainder carries a WIDTH+1 bit so that shifted >= 2^WIDTH is handled. The final remainder is always < divisor.
- Invariant at done (divisor != 0): quotient*divisor + remainder == dividend.

Test Plan:
- Basic: dividend=11, divisor=6, start pulse → done exactly 21 edges after the start edge; quotient=1, remainder=5, div_by_zero=0; busy high for 21 cycles.
- Large: dividend=1000000, divisor=7 → quotient=142857, remainder=1.
- Extremes:
  - 0xFFFFF/1 → quotient=0xFFFFF, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 0xFFFFF/0xFFFFF → quotient=1, remainder=0.
- Divide by zero: dividend=1234, divisor=0 → done on the edge after start (latency 1); quotient=0xFFFFF, remainder=1234, div_by_zero=1. The next valid division clears div_by_zero.
- Busy and done handling:
  - Start 100/3. At cycle 5, assert start with 50/5 → ignored; result is quotient=33, remainder=1.
  - Start held high continuously → divisions run back-to-back with one IDLE cycle between DONE and the next CALC.
- Reset:
  - Assert rst at iteration 10 of 1000/10 → next edge: busy=0, done=0, quotient=0, remainder=0.
  - A subsequent 1000/10 → quotient=100, remainder=0.
